// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one serial_tx engine between NUM_REQ byte requesters (round-robin) and sequences it.
// Latency: tx_start/tx_data valid the cycle after the req_valid&req_ready edge; about 12 baud ticks per byte.
// Backpressure: req_ready is offered only in IDLE, to one requester at a time; a stalled engine is abandoned by the watchdog.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_data      per-requester byte offer (byte i at [8i+7:8i])
//   req_ready               one-hot accept strobe (combinational)
//   grant_id, active        current owner of the engine, FSM not IDLE
//   tx_tick/tx_en/tx_start  engine baud tick, enable and start
//   tx_data                 byte handed to the engine
//   tx_busy/tx_done         engine status
//   err_timeout             one-cycle pulse when a byte is abandoned
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CLKS_PER_BIT   = 104,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 tx_tick,
  output logic                 tx_en,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 err_timeout
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  sel_inc;
  logic [WD_W-1:0]  wd_cnt;
  logic             valid_any;
  logic             accept;
  logic             wd_fire;

  // First valid requester at or after p, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] cand;
    logic            hit;
    rr_pick = p;
    hit     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(p) + k) % NUM_REQ);
      if (!hit && v[cand]) begin
        rr_pick = cand;
        hit     = 1'b1;
      end
    end
  endfunction

  // Free-running baud generator, independent of the FSM.
  assign tx_tick = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (tx_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign valid_any = |req_valid;
  assign sel       = rr_pick(req_valid, ptr);
  assign sel_inc   = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign accept    = (state == S_IDLE) && valid_any;
  // rst_n gating keeps req_ready low while reset is held even if a requester is already valid.
  assign req_ready = (accept && rst_n) ? (NUM_REQ'(1) << sel) : '0;
  assign active    = (state != S_IDLE);
  assign wd_fire   = (state != S_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // LAUNCH holds start across ticks: the engine only looks at start on tx_tick.
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_any) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        tx_start = 1'b1;
        tx_en    = 1'b1;
        if (tx_busy) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        tx_en = 1'b1;
        if (tx_done) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!tx_done && !tx_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (wd_fire) state_nxt = S_IDLE;
  end

  // Grant bookkeeping. ptr advances at acceptance, so a timed-out byte is not retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
    end else if (accept) begin
      ptr      <= sel_inc;
      grant_id <= sel;
      tx_data  <= req_data[{sel, 3'b000} +: 8];
    end
  end

  // Watchdog covers LAUNCH through RELEASE of one byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_fire;
      if (accept) begin
        wd_cnt <= '0;
      end else if ((state != S_IDLE) && !wd_fire) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 4;
  localparam int TMO     = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        active;
  logic        tx_tick;
  logic        tx_en;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        err_timeout;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic stall  = 1'b0;
  logic line_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .active(active),
    .tx_tick(tx_tick),
    .tx_en(tx_en),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serial_tx engine: acts only on tx_tick, records every line level it drives.
  typedef enum logic [2:0] {E_IDLE, E_START, E_DATA, E_STOP, E_DONE} e_state_t;
  e_state_t   e_st;
  logic [7:0] e_sh;
  int         e_bits;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_st    <= E_IDLE;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      e_sh    <= '0;
      e_bits  <= 0;
    end else if (tx_tick && !stall) begin
      case (e_st)
        E_IDLE: if (tx_en && tx_start) begin
          e_st    <= E_START;
          tx_busy <= 1'b1;
          e_sh    <= tx_data;
          line_q.push_back(1'b0);
        end
        E_START: begin
          line_q.push_back(e_sh[0]);
          e_sh   <= e_sh >> 1;
          e_bits <= 1;
          e_st   <= E_DATA;
        end
        E_DATA: begin
          if (e_bits == 8) begin
            line_q.push_back(1'b1);
            e_st <= E_STOP;
          end else begin
            line_q.push_back(e_sh[0]);
            e_sh   <= e_sh >> 1;
            e_bits <= e_bits + 1;
          end
        end
        E_STOP: begin
          tx_done <= 1'b1;
          e_st    <= E_DONE;
        end
        E_DONE: if (!tx_en) begin
          tx_done <= 1'b0;
          tx_busy <= 1'b0;
          e_st    <= E_IDLE;
        end
        default: e_st <= E_IDLE;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({req_ready, grant_id, active, tx_tick, tx_en, tx_start, tx_data, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b gid=%0d act=%b tick=%b en=%b st=%b data=%h err=%b, want all 0",
               req_ready, grant_id, active, tx_tick, tx_en, tx_start, tx_data, err_timeout);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_tick = (k % 4 == 3);
      checks++;
      if (tx_tick !== exp_tick) begin
        errors++;
        $display("FAIL reset_tick cycle %0d: got %b want %b", k, tx_tick, exp_tick);
      end
      checks++;
      if ({active, tx_en, tx_start, err_timeout, req_ready} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got act=%b en=%b st=%b err=%b rdy=%b want 0",
                 k, active, tx_en, tx_start, err_timeout, req_ready);
      end
    end
  endtask

  task automatic test_single();
    int         ready_cnt;
    int         busy_cyc;
    int         fall_cyc;
    bit         stable;
    bit         fin;
    logic [9:0] got_line;
    line_q.delete();
    req_data  = 32'h44A5_2211;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    ready_cnt = (req_ready[2] === 1'b1) ? 1 : 0;
    step();
    req_valid = '0;
    #1;
    checks++;
    if (grant_id !== 2'd2 || tx_data !== 8'hA5 || tx_start !== 1'b1 || tx_en !== 1'b1) begin
      errors++;
      $display("FAIL single_launch: got gid=%0d data=%h st=%b en=%b want 2 a5 1 1",
               grant_id, tx_data, tx_start, tx_en);
    end
    busy_cyc = -1;
    fall_cyc = -1;
    stable   = 1'b1;
    fin      = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (req_ready[2] === 1'b1) ready_cnt++;
      if (tx_data !== 8'hA5) stable = 1'b0;
      if (tx_busy === 1'b1 && busy_cyc < 0) busy_cyc = cyc;
      if (busy_cyc >= 0 && tx_start === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
      if (active === 1'b0) fin = 1'b1;
      else step();
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL single_idle_timeout: active=%b after 200 cycles, want 0", active);
    end
    checks++;
    if (busy_cyc < 0 || fall_cyc - busy_cyc != 1) begin
      errors++;
      $display("FAIL single_start_fall: got busy@%0d start_fall@%0d want fall one cycle after busy",
               busy_cyc, fall_cyc);
    end
    checks++;
    if (ready_cnt != 1) begin
      errors++;
      $display("FAIL single_ready_pulses: got %0d want 1", ready_cnt);
    end
    checks++;
    if (!stable || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data_stable: got data=%h stable=%b want a5 1", tx_data, stable);
    end
    got_line = '1;
    for (int i = 0; i < 10 && i < line_q.size(); i++) got_line[i] = line_q[i];
    checks++;
    if (line_q.size() != 10 || got_line !== 10'b1101001010) begin
      errors++;
      $display("FAIL single_line: got %0d levels %b want 10 levels 1101001010 (bit0 first)",
               line_q.size(), got_line);
    end
  endtask

  task automatic test_rr();
    logic [7:0] eb;
    do_reset();
    req_data  = 32'h4433_2211;
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      // Checked in the first IDLE cycle after RELEASE: no extra idle gap allowed.
      checks++;
      if (req_ready !== 4'(1 << (g % 4))) begin
        errors++;
        $display("FAIL rr_ready grant %0d: got %b want %b", g, req_ready, 4'(1 << (g % 4)));
      end
      step();
      eb = 8'(((g % 4) + 1) * 17);
      checks++;
      if (grant_id !== 2'(g % 4) || tx_data !== eb) begin
        errors++;
        $display("FAIL rr_grant %0d: got gid=%0d data=%h want %0d %h", g, grant_id, tx_data, g % 4, eb);
      end
      for (int k = 0; k < 200 && active === 1'b1; k++) step();
      checks++;
      if (active !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_timeout grant %0d: active=%b want 0", g, active);
      end
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_late();
    int early;
    bit saw_rel;
    req_data  = 32'h0000_5AC3;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL late_first_ready: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    for (int k = 0; k < 50 && tx_busy !== 1'b1; k++) step();
    step();
    checks++;
    if (active !== 1'b1 || tx_en !== 1'b1 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL late_wait_done: got act=%b en=%b st=%b want 1 1 0", active, tx_en, tx_start);
    end
    req_valid      = 4'b0010;
    req_data[7:0]  = 8'hFF;
    #1;
    early   = 0;
    saw_rel = 1'b0;
    for (int k = 0; k < 200 && active === 1'b1; k++) begin
      if (req_ready !== 4'b0000) early++;
      if (tx_en === 1'b0) saw_rel = 1'b1;
      step();
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL late_early_ready: got %0d busy cycles with req_ready set, want 0", early);
    end
    checks++;
    if (!saw_rel || active !== 1'b0) begin
      errors++;
      $display("FAIL late_release: got saw_release=%b active=%b want 1 0", saw_rel, active);
    end
    checks++;
    if (req_ready !== 4'b0010 || tx_data !== 8'hC3) begin
      errors++;
      $display("FAIL late_first_idle: got rdy=%b data=%h want 0010 c3", req_ready, tx_data);
    end
    step();
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL late_grant: got gid=%0d data=%h want 1 5a", grant_id, tx_data);
    end
    for (int k = 0; k < 200 && active === 1'b1; k++) step();
  endtask

  task automatic test_watchdog();
    int bad;
    stall     = 1'b1;
    req_data  = 32'h7766_0000;
    req_valid = 4'b1100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wd_ready: got %b want 0100", req_ready);
    end
    step();
    bad = 0;
    for (int k = 1; k <= 63; k++) begin
      step();
      if (err_timeout !== 1'b0 || active !== 1'b1 || tx_start !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wd_early: got %0d bad cycles before timeout, want 0", bad);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || active !== 1'b0 || tx_start !== 1'b0 || tx_en !== 1'b0) begin
      errors++;
      $display("FAIL wd_fire: got err=%b act=%b st=%b en=%b want 1 0 0 0",
               err_timeout, active, tx_start, tx_en);
    end
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wd_next_ready: got %b want 1000", req_ready);
    end
    step();
    req_valid = '0;
    stall     = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || grant_id !== 2'd3 || tx_data !== 8'h77 || active !== 1'b1) begin
      errors++;
      $display("FAIL wd_next_grant: got err=%b gid=%0d data=%h act=%b want 0 3 77 1",
               err_timeout, grant_id, tx_data, active);
    end
    for (int k = 0; k < 200 && active === 1'b1; k++) step();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL wd_recover: active=%b want 0", active);
    end
  endtask

  task automatic test_reset_mid();
    req_data  = 32'h0000_005A;
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    for (int k = 0; k < 50 && tx_busy !== 1'b1; k++) step();
    step();
    checks++;
    if (active !== 1'b1 || tx_en !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL mid_wait_done: got act=%b en=%b st=%b data=%h want 1 1 0 5a",
               active, tx_en, tx_start, tx_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({active, tx_en, tx_start, grant_id, tx_data, err_timeout, req_ready, tx_tick} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear: got act=%b en=%b st=%b gid=%0d data=%h err=%b rdy=%b tick=%b want 0",
               active, tx_en, tx_start, grant_id, tx_data, err_timeout, req_ready, tx_tick);
    end
    @(negedge clk);
    req_data  = 32'h0000_C33C;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ptr_reset: got rdy=%b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd0 || tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL mid_grant: got gid=%0d data=%h want 0 3c", grant_id, tx_data);
    end
    for (int k = 0; k < 200 && active === 1'b1; k++) step();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle_timeout: active=%b want 0", active);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_late();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `serial_tx` engine between `NUM_REQ` byte requesters and sequences it. The block does four things: it generates the engine's baud `tick`, picks a requester by round-robin, launches the byte with `start`/`en`, and tracks `busy`/`done` until the engine is idle again. It sits between the system-side producers and the single UART TX line, and a watchdog recovers from a stalled engine.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `CLKS_PER_BIT`, 104: `clk` cycles per baud `tick` (≥2).
- `TIMEOUT_CYCLES`, 4096: watchdog limit per byte, in `clk` cycles.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  requester i holds a byte.
- `req_data`  in  8*NUM_REQ  byte i sits at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  accept strobe; a byte transfers when `req_valid[i]` and `req_ready[i]` are both high at an edge.
- `grant_id`  out  clog2(NUM_REQ)  index of the requester currently owning the engine.
- `active`  out  1  high whenever the state is not IDLE.
- `tx_tick`  out  1  one-`clk` baud pulse that drives the engine `tick`.
- `tx_en`  out  1  engine `en`.
- `tx_start`  out  1  engine `start`.
- `tx_data`  out  8  engine `data_to_send`.
- `tx_busy`  in  1  engine `busy`.
- `tx_done`  in  1  engine `done`.
- `err_timeout`  out  1  one-`clk` pulse when the watchdog fires.

## Operation
- **Baud generator:** free-running counter 0..CLKS_PER_BIT-1. `tx_tick`=1 only when the counter is at CLKS_PER_BIT-1; the counter then wraps to 0. It runs in every state.
- **Round-robin pointer `ptr`:** reset value 0. The search order is ptr, ptr+1, … (mod NUM_REQ); the first index with `req_valid` set wins (`sel`). On each acceptance, `ptr` ← sel+1 mod NUM_REQ.
- **`req_ready[i]`** is combinational: `(state==IDLE) && valid_any && i==sel`. At most one bit is high at a time. Never high outside IDLE.
- **FSM states:** IDLE, LAUNCH, WAIT_DONE, RELEASE.
  - IDLE: on any `req_valid`, latch `req_data[sel]` into `tx_data`, set `grant_id`←sel, clear the watchdog, go to LAUNCH.
  - LAUNCH: `tx_start`=1, `tx_en`=1. Held until `tx_busy`=1 is sampled, then go to WAIT_DONE. Holding across ticks is required because the engine samples only on `tx_tick`.
  - WAIT_DONE: `tx_start`=0, `tx_en`=1. On `tx_done`=1, go to RELEASE.
  - RELEASE: `tx_en`=0. Wait for `tx_done`=0 and `tx_busy`=0 (engine back in its IDLE), then go to IDLE.
- **Watchdog:** counts `clk` cycles in LAUNCH, WAIT_DONE and RELEASE, and is cleared on entry to LAUNCH. When it reaches TIMEOUT_CYCLES-1: pulse `err_timeout`, force IDLE, drop `tx_start` and `tx_en`. `ptr` keeps its post-acceptance value, so the byte is dropped and not retried.
- **Reset values:** state=IDLE, `ptr`=0, baud counter=0, `tx_data`=0, `grant_id`=0. `req_ready`, `tx_tick`, `tx_en`, `tx_start`, `active` and `err_timeout` are all 0.
- **Reset mid-operation:** everything returns to reset values immediately. The accepted byte is lost.

## Timing
- **Acceptance to launch:** the handshake edge is cycle 0. `tx_start` and `tx_data` are valid from cycle 1.
- **Engine start:** `tx_start` stays high for 1..CLKS_PER_BIT+1 cycles until the engine's first tick. The engine raises `busy` one tick after `start`.
- **Per-byte duration:** about 11..12 ticks from acceptance to return to IDLE, plus the RELEASE wait for one engine IDLE tick.
- **Back-to-back:** the next `req_ready` may assert in the first IDLE cycle after RELEASE. There are no idle cycles beyond that.
- **Simultaneous requests:** exactly one is granted per IDLE visit. A requester that drops `req_valid` before being granted is simply skipped.
- **`tx_data` stability:** held constant from LAUNCH until the next acceptance.

## Test plan
- **Reset:** apply reset, then release, with CLKS_PER_BIT=4. All outputs are 0; `tx_tick` pulses at cycles 3, 7, 11 after release.
- **Single requester:** `req_valid[2]`=1, data 0xA5, behavioural engine attached. `req_ready[2]` pulses once; `grant_id`=2; `tx_data`=0xA5; `tx_start` falls the cycle after `tx_busy` rises; the line shows 0,1,0,1,0,0,1,0,1 then 1.
- **Round-robin fairness:** all four `req_valid` held high with distinct bytes. Grant order is 0,1,2,3,0 and no requester is granted twice in a row.
- **Late request while busy:** `req_valid[1]` asserted during WAIT_DONE. `req_ready[1]` stays 0 until the IDLE cycle after RELEASE.
- **Watchdog, stalled engine:** `tx_busy` tied 0, TIMEOUT_CYCLES=64. `err_timeout` pulses 64 cycles after LAUNCH entry; the FSM returns to IDLE and the next requester is granted.
- **Reset mid-byte:** assert `rst_n`=0 during WAIT_DONE. Outputs clear asynchronously; after release, `ptr`=0 and requester 0 is granted first.
